// File: rtl/eco32f_pkg.sv
// Shared types and encodings for the eco32f Wishbone arbiter.
package eco32f_pkg;

   localparam int unsigned ADR_W = 32;
   localparam int unsigned DAT_W = 32;
   localparam int unsigned SEL_W = 4;
   localparam int unsigned CTI_W = 3;
   localparam int unsigned BTE_W = 2;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWN_I = 2'd1,
      ARB_OWN_D = 2'd2
   } arb_state_e;

   localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
   localparam logic [CTI_W-1:0] CTI_INC     = 3'b010;
   localparam logic [CTI_W-1:0] CTI_EOB     = 3'b111;
   localparam logic [BTE_W-1:0] BTE_WRAP8   = 2'b10;

   // Master-to-slave request payload of one Wishbone port
   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic             stb;
      logic             cyc;
      logic [SEL_W-1:0] sel;
      logic             we;
      logic [CTI_W-1:0] cti;
      logic [BTE_W-1:0] bte;
      logic [DAT_W-1:0] dat;
   } wb_req_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] max);
      return (v >= max) ? max : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/eco32f_arb_watchdog.sv
// Bus-cycle watchdog: expires after TIMEOUT stalled strobe cycles.
// Built only when ECO32F_ARB_WATCHDOG_EN is defined.
`ifdef ECO32F_ARB_WATCHDOG_EN
module eco32f_arb_watchdog #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic expire
);

   localparam int unsigned WD_W = 8;

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

   always_comb begin
      wd_cnt_d = wd_cnt_q;
      if (clear)
         wd_cnt_d = '0;
      else if (run)
         wd_cnt_d = wd_cnt_q + WD_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         wd_cnt_q <= '0;
      else
         wd_cnt_q <= wd_cnt_d;
   end

   assign expire = (wd_cnt_q == WD_W'(TIMEOUT));

endmodule
`endif

// File: rtl/eco32f_wb_arbiter.sv
// Two-master Wishbone arbiter (fetch vs. LSU), grant held for a whole bus cycle.
// Optional hung-slave watchdog enabled with ECO32F_ARB_WATCHDOG_EN.
module eco32f_wb_arbiter
   import eco32f_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADR_W-1:0] iwb_adr_i,
   input  logic             iwb_stb_i,
   input  logic             iwb_cyc_i,
   input  logic [CTI_W-1:0] iwb_cti_i,
   input  logic [BTE_W-1:0] iwb_bte_i,
   output logic             iwb_ack_o,
   output logic             iwb_err_o,
   input  logic [ADR_W-1:0] dwb_adr_i,
   input  logic             dwb_stb_i,
   input  logic             dwb_cyc_i,
   input  logic [SEL_W-1:0] dwb_sel_i,
   input  logic             dwb_we_i,
   input  logic [CTI_W-1:0] dwb_cti_i,
   input  logic [BTE_W-1:0] dwb_bte_i,
   input  logic [DAT_W-1:0] dwb_dat_i,
   output logic             dwb_ack_o,
   output logic             dwb_err_o,
   output logic [ADR_W-1:0] mwb_adr_o,
   output logic             mwb_stb_o,
   output logic             mwb_cyc_o,
   output logic [SEL_W-1:0] mwb_sel_o,
   output logic             mwb_we_o,
   output logic [CTI_W-1:0] mwb_cti_o,
   output logic [BTE_W-1:0] mwb_bte_o,
   output logic [DAT_W-1:0] mwb_dat_o,
   input  logic             mwb_ack_i,
   input  logic             mwb_err_i,
   input  logic             mwb_rty_i,
   output logic             grant_d_o
);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   wb_req_t          iwb_req, dwb_req, mwb_req;
   logic             wd_expire;
   logic             bus_rsp;

   assign bus_rsp = mwb_ack_i | mwb_err_i | mwb_rty_i;

   // Fetch port is read-only and always word-wide
   assign iwb_req = '{adr: iwb_adr_i, stb: iwb_stb_i, cyc: iwb_cyc_i, sel: {SEL_W{1'b1}},
                      we: 1'b0, cti: iwb_cti_i, bte: iwb_bte_i, dat: '0};
   assign dwb_req = '{adr: dwb_adr_i, stb: dwb_stb_i, cyc: dwb_cyc_i, sel: dwb_sel_i,
                      we: dwb_we_i, cti: dwb_cti_i, bte: dwb_bte_i, dat: dwb_dat_i};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ARB_IDLE;
         starve_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      mwb_req      = '0;
      mwb_req.cti  = CTI_CLASSIC;
      iwb_ack_o    = 1'b0;
      iwb_err_o    = 1'b0;
      dwb_ack_o    = 1'b0;
      dwb_err_o    = 1'b0;

      unique case (state_q)
         ARB_IDLE: begin
            // Data wins unless fetch has already been passed over STARVE_MAX times
            if (dwb_cyc_i && (!iwb_cyc_i || starve_cnt_q < CNT_W'(STARVE_MAX))) begin
               state_d      = ARB_OWN_D;
               starve_cnt_d = iwb_cyc_i ? sat_inc(starve_cnt_q, CNT_W'(STARVE_MAX)) : '0;
            end else if (iwb_cyc_i) begin
               state_d      = ARB_OWN_I;
               starve_cnt_d = '0;
            end else begin
               starve_cnt_d = '0;
            end
         end
         ARB_OWN_I: begin
            mwb_req   = iwb_req;
            iwb_ack_o = mwb_ack_i;
            iwb_err_o = mwb_err_i | mwb_rty_i | wd_expire;
            if (!iwb_cyc_i || wd_expire)
               state_d = ARB_IDLE;
         end
         ARB_OWN_D: begin
            mwb_req   = dwb_req;
            dwb_ack_o = mwb_ack_i;
            dwb_err_o = mwb_err_i | mwb_rty_i | wd_expire;
            if (!dwb_cyc_i || wd_expire)
               state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase

      // A watchdog abort ends the bus cycle immediately
      if (wd_expire) begin
         mwb_req.cyc = 1'b0;
         mwb_req.stb = 1'b0;
      end
   end

   assign mwb_adr_o = mwb_req.adr;
   assign mwb_stb_o = mwb_req.stb;
   assign mwb_cyc_o = mwb_req.cyc;
   assign mwb_sel_o = mwb_req.sel;
   assign mwb_we_o  = mwb_req.we;
   assign mwb_cti_o = mwb_req.cti;
   assign mwb_bte_o = mwb_req.bte;
   assign mwb_dat_o = mwb_req.dat;
   assign grant_d_o = (state_q == ARB_OWN_D);

`ifdef ECO32F_ARB_WATCHDOG_EN
   logic wd_run, wd_clear;

   assign wd_run   = (state_q != ARB_IDLE) && mwb_req.stb && !bus_rsp;
   assign wd_clear = (state_q == ARB_IDLE) || bus_rsp || wd_expire;

   eco32f_arb_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk   (clk),
      .rst   (rst),
      .run   (wd_run),
      .clear (wd_clear),
      .expire(wd_expire)
   );
`else
   logic unused_wd;

   assign wd_expire = 1'b0;
   assign unused_wd = ^{8'(TIMEOUT), bus_rsp};
`endif

endmodule

// File: tb/tb_eco32f_wb_arbiter.sv
// Scoreboard bench for eco32f_wb_arbiter: directed master/slave traffic, event monitor.
module tb_eco32f_wb_arbiter;
   import eco32f_pkg::*;

   localparam logic [1:0] EV_GRANT = 2'd0, EV_ACK = 2'd1, EV_ERR = 2'd2;
   localparam logic [1:0] WHO_I = 2'b01, WHO_D = 2'b10;

   typedef struct packed {
      logic [1:0]  kind;
      logic [1:0]  who;
      logic        we;
      logic [31:0] adr;
      logic [7:0]  gap;   // required idle cycles before a grant; 0 = any >= 1
   } ev_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] iwb_adr_i = '0;
   logic        iwb_stb_i = 1'b0, iwb_cyc_i = 1'b0;
   logic [2:0]  iwb_cti_i = '0;
   logic [1:0]  iwb_bte_i = '0;
   logic        iwb_ack_o, iwb_err_o;
   logic [31:0] dwb_adr_i = '0, dwb_dat_i = '0;
   logic        dwb_stb_i = 1'b0, dwb_cyc_i = 1'b0, dwb_we_i = 1'b0;
   logic [3:0]  dwb_sel_i = '0;
   logic [2:0]  dwb_cti_i = '0;
   logic [1:0]  dwb_bte_i = '0;
   logic        dwb_ack_o, dwb_err_o;
   logic [31:0] mwb_adr_o, mwb_dat_o;
   logic        mwb_stb_o, mwb_cyc_o, mwb_we_o;
   logic [3:0]  mwb_sel_o;
   logic [2:0]  mwb_cti_o;
   logic [1:0]  mwb_bte_o;
   logic        mwb_ack_i = 1'b0, mwb_err_i = 1'b0, mwb_rty_i = 1'b0;
   logic        grant_d_o;

   int  tests = 0;
   int  fails = 0;
   ev_t exp_q[$];
   int  slave_wait = 0;
   int  slave_rsp  = 0;    // 0 ack, 1 retry, 2 never respond
   bit  abort      = 1'b0;

   eco32f_wb_arbiter #(.STARVE_MAX(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .iwb_adr_i(iwb_adr_i), .iwb_stb_i(iwb_stb_i), .iwb_cyc_i(iwb_cyc_i),
      .iwb_cti_i(iwb_cti_i), .iwb_bte_i(iwb_bte_i), .iwb_ack_o(iwb_ack_o), .iwb_err_o(iwb_err_o),
      .dwb_adr_i(dwb_adr_i), .dwb_stb_i(dwb_stb_i), .dwb_cyc_i(dwb_cyc_i), .dwb_sel_i(dwb_sel_i),
      .dwb_we_i(dwb_we_i), .dwb_cti_i(dwb_cti_i), .dwb_bte_i(dwb_bte_i), .dwb_dat_i(dwb_dat_i),
      .dwb_ack_o(dwb_ack_o), .dwb_err_o(dwb_err_o),
      .mwb_adr_o(mwb_adr_o), .mwb_stb_o(mwb_stb_o), .mwb_cyc_o(mwb_cyc_o), .mwb_sel_o(mwb_sel_o),
      .mwb_we_o(mwb_we_o), .mwb_cti_o(mwb_cti_o), .mwb_bte_o(mwb_bte_o), .mwb_dat_o(mwb_dat_o),
      .mwb_ack_i(mwb_ack_i), .mwb_err_i(mwb_err_i), .mwb_rty_i(mwb_rty_i),
      .grant_d_o(grant_d_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic void push(input logic [1:0] kind, input logic [1:0] who, input logic we,
                                input logic [31:0] adr, input logic [7:0] gap);
      exp_q.push_back('{kind: kind, who: who, we: we, adr: adr, gap: gap});
   endfunction

   task automatic check_ev(input logic [1:0] kind, input logic [1:0] who, input logic we,
                           input logic [31:0] adr, input logic [7:0] gap);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL sb_unexpected actual kind=%0d who=%b adr=%h required=no event", kind, who, adr);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.who != who || e.we != we || e.adr != adr ||
             (kind == EV_GRANT && (gap == 0 || (e.gap != 0 && e.gap != gap)))) begin
            fails++;
            $display("FAIL sb_event actual kind=%0d who=%b we=%b adr=%h gap=%0d required kind=%0d who=%b we=%b adr=%h gap=%0d",
                     kind, who, we, adr, gap, e.kind, e.who, e.we, e.adr, e.gap);
         end
      end
   endtask

   function automatic logic [2:0] cti_of(input int k, input int n);
      if (n == 1) return CTI_CLASSIC;
      if (k == n - 1) return CTI_EOB;
      return CTI_INC;
   endfunction

   task automatic drive(input bit is_d, input logic [31:0] adr, input int k, input int n,
                        input bit we, input bit on);
      logic [1:0] bte;
      bte = (n == 1 || !on) ? 2'b00 : BTE_WRAP8;
      if (is_d) begin
         dwb_adr_i = on ? adr : '0;     dwb_cti_i = on ? cti_of(k, n) : '0;
         dwb_bte_i = bte;               dwb_we_i  = we & on;
         dwb_sel_i = on ? 4'hF : 4'h0;  dwb_dat_i = on ? ~adr : '0;
         dwb_cyc_i = on;                dwb_stb_i = on;
      end else begin
         iwb_adr_i = on ? adr : '0;     iwb_cti_i = on ? cti_of(k, n) : '0;
         iwb_bte_i = bte;
         iwb_cyc_i = on;                iwb_stb_i = on;
      end
   endtask

   // Master model: n-beat transfer, ends on last ack, err or abort
   task automatic xfer(input bit is_d, input logic [31:0] base, input int n, input bit we);
      int  k = 0;
      int  guard = 0;
      bit  done = 1'b0;
      @(negedge clk); #2;
      drive(is_d, base, 0, n, we, 1'b1);
      while (!done) begin
         @(negedge clk); #2;
         guard++;
         if (abort) done = 1'b1;
         else if (is_d ? dwb_ack_o : iwb_ack_o) begin
            k++;
            if (k == n) done = 1'b1;
            else drive(is_d, base + 32'(4 * k), k, n, we, 1'b1);
         end else if (is_d ? dwb_err_o : iwb_err_o) done = 1'b1;
         else if (guard > 300) begin
            tests++; fails++;
            $display("FAIL xfer_timeout actual=no response required=response adr=%h", base);
            done = 1'b1;
         end
      end
      drive(is_d, '0, 0, 1, 1'b0, 1'b0);
   endtask

   // Slave model: responds slave_wait cycles after strobe
   initial begin
      int wcnt = 0;
      forever begin
         @(posedge clk); #1;
         mwb_ack_i = 1'b0; mwb_rty_i = 1'b0;
         if (rst && mwb_cyc_o && mwb_stb_o && slave_rsp != 2) begin
            if (wcnt >= slave_wait) begin
               wcnt = 0;
               if (slave_rsp == 1) mwb_rty_i = 1'b1; else mwb_ack_i = 1'b1;
            end else wcnt++;
         end else wcnt = 0;
      end
   end

   // Monitor: every grant, ack and err is matched against the scoreboard
   initial begin
      logic prev_cyc = 1'b0;
      int   gap = 255;
      forever begin
         @(negedge clk);
         if (mwb_cyc_o && !prev_cyc)
            check_ev(EV_GRANT, {grant_d_o, !grant_d_o}, mwb_we_o, mwb_adr_o, 8'(gap));
         if (iwb_ack_o || dwb_ack_o)
            check_ev(EV_ACK, {dwb_ack_o, iwb_ack_o}, mwb_we_o, mwb_adr_o, 8'd0);
         if (iwb_err_o || dwb_err_o)
            check_ev(EV_ERR, {dwb_err_o, iwb_err_o}, mwb_we_o, mwb_adr_o, 8'd0);
         gap      = mwb_cyc_o ? 0 : ((gap < 255) ? gap + 1 : 255);
         prev_cyc = mwb_cyc_o;
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      #1 rst = 1'b0;
      #2;
      chk("rst_cyc", 32'(mwb_cyc_o), 0);   chk("rst_stb", 32'(mwb_stb_o), 0);
      chk("rst_we", 32'(mwb_we_o), 0);     chk("rst_grant_d", 32'(grant_d_o), 0);
      chk("rst_iack", 32'(iwb_ack_o), 0);  chk("rst_dack", 32'(dwb_ack_o), 0);
      chk("rst_ierr", 32'(iwb_err_o), 0);  chk("rst_derr", 32'(dwb_err_o), 0);
      chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
      chk("rst_starve", 32'(dut.starve_cnt_q), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Fetch-only single read, two wait states
      slave_wait = 2;
      push(EV_GRANT, WHO_I, 1'b0, 32'h0000_1000, 8'd0);
      push(EV_ACK,   WHO_I, 1'b0, 32'h0000_1000, 8'd0);
      fork
         xfer(1'b0, 32'h0000_1000, 1, 1'b0);
         begin
            @(negedge clk); #3;
            chk("lat_cyc_same_cycle", 32'(mwb_cyc_o), 0);
            @(negedge clk); #3;
            chk("lat_cyc_next_cycle", 32'(mwb_cyc_o), 1);
            chk("lat_grant_d", 32'(grant_d_o), 0);
         end
      join
      repeat (3) @(negedge clk);

      // Retry is reported to the owner as an error
      slave_wait = 0; slave_rsp = 1;
      push(EV_GRANT, WHO_I, 1'b0, 32'h0000_1100, 8'd0);
      push(EV_ERR,   WHO_I, 1'b0, 32'h0000_1100, 8'd0);
      xfer(1'b0, 32'h0000_1100, 1, 1'b0);
      slave_rsp = 0;
      repeat (3) @(negedge clk);

      // Simultaneous requests: data first, one idle cycle, then fetch
      slave_wait = 1;
      push(EV_GRANT, WHO_D, 1'b1, 32'h0000_2000, 8'd0);
      push(EV_ACK,   WHO_D, 1'b1, 32'h0000_2000, 8'd0);
      push(EV_GRANT, WHO_I, 1'b0, 32'h0000_1004, 8'd1);
      push(EV_ACK,   WHO_I, 1'b0, 32'h0000_1004, 8'd0);
      fork
         xfer(1'b1, 32'h0000_2000, 1, 1'b1);
         xfer(1'b0, 32'h0000_1004, 1, 1'b0);
      join
      repeat (3) @(negedge clk);

      // 8-beat data refill with a fetch request arriving mid-burst
      push(EV_GRANT, WHO_D, 1'b0, 32'h0000_3000, 8'd0);
      for (int k = 0; k < 8; k++) push(EV_ACK, WHO_D, 1'b0, 32'h0000_3000 + 32'(4 * k), 8'd0);
      push(EV_GRANT, WHO_I, 1'b0, 32'h0000_1008, 8'd1);
      push(EV_ACK,   WHO_I, 1'b0, 32'h0000_1008, 8'd0);
      fork
         xfer(1'b1, 32'h0000_3000, 8, 1'b0);
         begin
            repeat (6) @(negedge clk);
            xfer(1'b0, 32'h0000_1008, 1, 1'b0);
         end
      join
      repeat (3) @(negedge clk);

      // Starvation: fetch is forced in as the 5th grant
      slave_wait = 0;
      push(EV_GRANT, WHO_D, 1'b1, 32'h0000_4000, 8'd0);
      push(EV_ACK,   WHO_D, 1'b1, 32'h0000_4000, 8'd0);
      for (int k = 1; k < 4; k++) begin
         push(EV_GRANT, WHO_D, 1'b1, 32'h0000_4000 + 32'(4 * k), 8'd1);
         push(EV_ACK,   WHO_D, 1'b1, 32'h0000_4000 + 32'(4 * k), 8'd0);
      end
      push(EV_GRANT, WHO_I, 1'b0, 32'h0000_100C, 8'd1);
      push(EV_ACK,   WHO_I, 1'b0, 32'h0000_100C, 8'd0);
      for (int k = 4; k < 6; k++) begin
         push(EV_GRANT, WHO_D, 1'b1, 32'h0000_4000 + 32'(4 * k), 8'd1);
         push(EV_ACK,   WHO_D, 1'b1, 32'h0000_4000 + 32'(4 * k), 8'd0);
      end
      fork
         for (int k = 0; k < 6; k++) xfer(1'b1, 32'h0000_4000 + 32'(4 * k), 1, 1'b1);
         xfer(1'b0, 32'h0000_100C, 1, 1'b0);
      join
      chk("starve_cleared", 32'(dut.starve_cnt_q), 0);
      repeat (3) @(negedge clk);

      // Asynchronous reset during beat 4 of a data burst
      slave_wait = 1;
      push(EV_GRANT, WHO_D, 1'b0, 32'h0000_5000, 8'd0);
      for (int k = 0; k < 4; k++) push(EV_ACK, WHO_D, 1'b0, 32'h0000_5000 + 32'(4 * k), 8'd0);
      fork
         xfer(1'b1, 32'h0000_5000, 8, 1'b0);
         begin
            int n = 0;
            int g = 0;
            while (n < 4 && g < 200) begin
               @(negedge clk);
               if (dwb_ack_o) n++;
               g++;
            end
            @(negedge clk); #3;
            chk("rstmid_pre_cyc", 32'(mwb_cyc_o), 1);
            abort = 1'b1;
            rst   = 1'b0;
            #1;
            chk("rstmid_cyc", 32'(mwb_cyc_o), 0);
            chk("rstmid_stb", 32'(mwb_stb_o), 0);
            chk("rstmid_grant_d", 32'(grant_d_o), 0);
            repeat (2) @(negedge clk);
            rst = 1'b1;
         end
      join
      abort = 1'b0;
      @(negedge clk);
      chk("rstmid_state", 32'(dut.state_q), 32'(ARB_IDLE));
      chk("rstmid_starve", 32'(dut.starve_cnt_q), 0);
      chk("rstmid_idle_cyc", 32'(mwb_cyc_o), 0);
      repeat (3) @(negedge clk);

`ifdef ECO32F_ARB_WATCHDOG_EN
      // Never-acked data write: watchdog error 16 cycles after strobe
      slave_rsp = 2;
      push(EV_GRANT, WHO_D, 1'b1, 32'h0000_6000, 8'd0);
      push(EV_ERR,   WHO_D, 1'b1, 32'h0000_6000, 8'd0);
      fork
         xfer(1'b1, 32'h0000_6000, 1, 1'b1);
         begin
            int g = 0;
            int n = 0;
            while (!mwb_stb_o && g < 50) begin @(negedge clk); g++; end
            while (!dwb_err_o && n < 40) begin @(negedge clk); n++; end
            chk("wd_latency", 32'(n), 16);
            chk("wd_cyc_forced", 32'(mwb_cyc_o), 0);
            @(negedge clk);
            chk("wd_err_one_cycle", 32'(dwb_err_o), 0);
            chk("wd_state_idle", 32'(dut.state_q), 32'(ARB_IDLE));
         end
      join
      slave_rsp = 0;
      repeat (3) @(negedge clk);
`endif

      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
